// File: rtl/fwd_hazard_unit_if.sv
// Operand-forwarding bundle between ID/RF control and the forwarding/hazard unit.
// master drives the issue group and sources; slave returns mux selects, stall and counters.
interface fwd_hazard_unit_if #(
  parameter int WAYS  = 2,
  parameter int RA_W  = 3,
  parameter int SEL_W = 3,
  parameter int CNT_W = 16
);
  logic                     advance;
  logic                     flush;
  logic [WAYS-1:0]          issue_valid;
  logic [WAYS-1:0]          issue_wb;
  logic [WAYS-1:0]          issue_load;
  logic [WAYS*RA_W-1:0]     issue_dest;
  logic [2*WAYS*RA_W-1:0]   src_addr;
  logic [2*WAYS-1:0]        src_used;
  logic [2*WAYS*SEL_W-1:0]  fwd_sel;
  logic                     stall;
  logic [CNT_W-1:0]         stall_cnt;
  logic [CNT_W-1:0]         fwd_cnt;

  modport master (
    output advance, flush, issue_valid, issue_wb, issue_load, issue_dest, src_addr, src_used,
    input  fwd_sel, stall, stall_cnt, fwd_cnt
  );

  modport slave (
    input  advance, flush, issue_valid, issue_wb, issue_load, issue_dest, src_addr, src_used,
    output fwd_sel, stall, stall_cnt, fwd_cnt
  );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Forwarding-select and load-use stall generator over a STAGES x WAYS producer history.
// Selects/stall are combinational (zero latency); history and counters move only on advance.
module fwd_hazard_unit #(
  parameter int WAYS        = 2,
  parameter int STAGES      = 3,
  parameter int RA_W        = 3,
  parameter int LOAD_STAGES = 1,
  parameter int SEL_W       = $clog2(STAGES*WAYS+1),
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  fwd_hazard_unit_if.slave  bus
);

  typedef struct packed {
    logic            valid;
    logic            wb;
    logic            load;
    logic [RA_W-1:0] dest;
  } entry_t;

  entry_t                  hist [STAGES][WAYS];
  logic [SEL_W-1:0]        sel  [2*WAYS];
  logic [2*WAYS-1:0]       hit_load;
  logic [2*WAYS*SEL_W-1:0] fwd_sel_int;
  logic                    stall_int;
  logic                    any_fwd;
  logic [CNT_W-1:0]        stall_cnt_q;
  logic [CNT_W-1:0]        fwd_cnt_q;

  // Scan oldest to youngest so the last hit (lowest stage, highest way) wins.
  always_comb begin
    stall_int   = 1'b0;
    any_fwd     = 1'b0;
    fwd_sel_int = '0;
    hit_load    = '0;
    for (int o = 0; o < 2*WAYS; o++) begin
      sel[o] = '0;
      for (int k = STAGES-1; k >= 0; k--) begin
        for (int w = 0; w < WAYS; w++) begin
          if (bus.src_used[o] && hist[k][w].valid && hist[k][w].wb &&
              hist[k][w].dest == bus.src_addr[o*RA_W +: RA_W]) begin
            sel[o]      = SEL_W'(1 + k*WAYS + w);
            hit_load[o] = hist[k][w].load && (k < LOAD_STAGES);
          end
        end
      end
      fwd_sel_int[o*SEL_W +: SEL_W] = sel[o];
      any_fwd   = any_fwd | (sel[o] != '0);
      stall_int = stall_int | hit_load[o];
    end
  end

  assign bus.fwd_sel   = fwd_sel_int;
  assign bus.stall     = stall_int;
  assign bus.stall_cnt = stall_cnt_q;
  assign bus.fwd_cnt   = fwd_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++)
        for (int w = 0; w < WAYS; w++)
          hist[k][w] <= '0;
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else if (bus.advance) begin
      for (int k = STAGES-1; k >= 1; k--)
        hist[k] <= hist[k-1];
      // A stalled or flushed group enters as a bubble; a stalled one is re-presented.
      for (int w = 0; w < WAYS; w++)
        hist[0][w] <= '{valid: bus.issue_valid[w] & ~stall_int & ~bus.flush,
                        wb:    bus.issue_wb[w],
                        load:  bus.issue_load[w],
                        dest:  bus.issue_dest[w*RA_W +: RA_W]};
      if (stall_int && stall_cnt_q != '1)
        stall_cnt_q <= stall_cnt_q + 1'b1;
      if (any_fwd && fwd_cnt_q != '1)
        fwd_cnt_q <= fwd_cnt_q + 1'b1;
    end else if (bus.flush) begin
      for (int w = 0; w < WAYS; w++)
        hist[0][w].valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench: default-parameter unit for forwarding/stall/flush behaviour,
// plus a narrow-counter instance so saturation is reachable in a short run.
module tb_fwd_hazard_unit;
  logic clk = 1'b0;
  logic reset;
  logic rs;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit_if #(.WAYS(2), .RA_W(3), .SEL_W(3), .CNT_W(16)) b ();
  fwd_hazard_unit_if #(.WAYS(2), .RA_W(3), .SEL_W(3), .CNT_W(6))  bs ();

  fwd_hazard_unit dut (.clk(clk), .reset(reset), .bus(b));
  fwd_hazard_unit #(.CNT_W(6)) dut_sat (.clk(clk), .reset(rs), .bus(bs));

  function automatic logic [2:0] sel_of(input int o);
    return b.fwd_sel[o*3 +: 3];
  endfunction

  task automatic clear_inputs();
    b.advance = 0; b.flush = 0; b.issue_valid = '0; b.issue_wb = '0;
    b.issue_load = '0; b.issue_dest = '0; b.src_addr = '0; b.src_used = '0;
  endtask

  task automatic set_way(input int w, input logic v, input logic wb, input logic ld,
                         input logic [2:0] d);
    b.issue_valid[w] = v; b.issue_wb[w] = wb; b.issue_load[w] = ld;
    b.issue_dest[w*3 +: 3] = d;
  endtask

  task automatic set_src(input int o, input logic used, input logic [2:0] a);
    b.src_used[o] = used; b.src_addr[o*3 +: 3] = a;
  endtask

  task automatic cycle();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1; clear_inputs();
    cycle();
    reset = 0; #1;
  endtask

  task automatic test_reset();
    reset = 1; clear_inputs();
    set_src(0, 1, 3'd0); set_src(3, 1, 3'd0);
    #1;
    checks++; if (b.fwd_sel !== '0) begin errors++; $display("FAIL reset_sel: got %h expected 0", b.fwd_sel); end
    checks++; if (b.stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", b.stall); end
    checks++; if (b.stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall_cnt: got %0d expected 0", b.stall_cnt); end
    checks++; if (b.fwd_cnt !== 16'd0) begin errors++; $display("FAIL reset_fwd_cnt: got %0d expected 0", b.fwd_cnt); end
    // Group offered while reset is held must not enter.
    b.advance = 1; set_way(0, 1, 1, 0, 3'd0);
    cycle();
    checks++; if (sel_of(0) !== 3'd0) begin errors++; $display("FAIL reset_hold_sel: got %0d expected 0", sel_of(0)); end
    reset = 0; clear_inputs(); set_src(0, 1, 3'd0); #1;
    checks++; if (sel_of(0) !== 3'd0) begin errors++; $display("FAIL post_reset_sel: got %0d expected 0", sel_of(0)); end
  endtask

  task automatic test_way_priority();
    do_reset();
    b.advance = 1; set_way(0, 1, 1, 0, 3'd3); set_way(1, 1, 1, 0, 3'd3);
    cycle();
    b.issue_valid = '0; set_src(0, 1, 3'd3); #1;
    checks++; if (sel_of(0) !== 3'd2) begin errors++; $display("FAIL prio_stage0: got %0d expected 2", sel_of(0)); end
    checks++; if (b.stall !== 1'b0) begin errors++; $display("FAIL prio_stall: got %b expected 0", b.stall); end
    cycle();
    checks++; if (sel_of(0) !== 3'd4) begin errors++; $display("FAIL prio_stage1: got %0d expected 4", sel_of(0)); end
    checks++; if (b.fwd_cnt !== 16'd1) begin errors++; $display("FAIL prio_fwd_cnt1: got %0d expected 1", b.fwd_cnt); end
    b.advance = 0;
    cycle();
    checks++; if (sel_of(0) !== 3'd4) begin errors++; $display("FAIL hold_sel: got %0d expected 4", sel_of(0)); end
    checks++; if (b.fwd_cnt !== 16'd1) begin errors++; $display("FAIL hold_fwd_cnt: got %0d expected 1", b.fwd_cnt); end
    b.advance = 1;
    cycle();
    checks++; if (sel_of(0) !== 3'd6) begin errors++; $display("FAIL prio_stage2: got %0d expected 6", sel_of(0)); end
    cycle();
    checks++; if (sel_of(0) !== 3'd0) begin errors++; $display("FAIL prio_discard: got %0d expected 0", sel_of(0)); end
    checks++; if (b.fwd_cnt !== 16'd3) begin errors++; $display("FAIL prio_fwd_cnt3: got %0d expected 3", b.fwd_cnt); end
  endtask

  task automatic test_load_use();
    do_reset();
    b.advance = 1; set_way(0, 1, 1, 1, 3'd5);
    cycle();
    set_way(0, 0, 0, 0, 3'd0); set_way(1, 1, 1, 0, 3'd6); set_src(3, 1, 3'd5); #1;
    checks++; if (b.stall !== 1'b1) begin errors++; $display("FAIL lu_stall: got %b expected 1", b.stall); end
    checks++; if (sel_of(3) !== 3'd1) begin errors++; $display("FAIL lu_sel_s0: got %0d expected 1", sel_of(3)); end
    cycle();
    checks++; if (b.stall !== 1'b0) begin errors++; $display("FAIL lu_nostall: got %b expected 0", b.stall); end
    checks++; if (sel_of(3) !== 3'd3) begin errors++; $display("FAIL lu_sel_s1: got %0d expected 3", sel_of(3)); end
    checks++; if (b.stall_cnt !== 16'd1) begin errors++; $display("FAIL lu_stall_cnt: got %0d expected 1", b.stall_cnt); end
    cycle();
    b.issue_valid = '0; b.src_used = '0; set_src(0, 1, 3'd6); #1;
    checks++; if (sel_of(0) !== 3'd2) begin errors++; $display("FAIL lu_reissued: got %0d expected 2", sel_of(0)); end
    checks++; if (b.fwd_cnt !== 16'd2) begin errors++; $display("FAIL lu_fwd_cnt: got %0d expected 2", b.fwd_cnt); end
  endtask

  task automatic test_age_override();
    do_reset();
    b.advance = 1; set_way(0, 1, 1, 0, 3'd2); cycle();
    set_way(0, 1, 1, 1, 3'd2); cycle();
    b.advance = 0; b.issue_valid = '0; set_src(0, 1, 3'd2); #1;
    checks++; if (b.stall !== 1'b1) begin errors++; $display("FAIL age_young_load_stall: got %b expected 1", b.stall); end
    checks++; if (sel_of(0) !== 3'd1) begin errors++; $display("FAIL age_young_load_sel: got %0d expected 1", sel_of(0)); end
    do_reset();
    b.advance = 1; set_way(0, 1, 1, 1, 3'd2); cycle();
    set_way(0, 1, 1, 0, 3'd2); cycle();
    b.advance = 0; b.issue_valid = '0; set_src(0, 1, 3'd2); #1;
    checks++; if (b.stall !== 1'b0) begin errors++; $display("FAIL age_young_alu_stall: got %b expected 0", b.stall); end
    checks++; if (sel_of(0) !== 3'd1) begin errors++; $display("FAIL age_young_alu_sel: got %0d expected 1", sel_of(0)); end
    do_reset();
    b.advance = 1; set_way(0, 1, 1, 1, 3'd4); set_way(1, 1, 1, 0, 3'd4); cycle();
    b.advance = 0; b.issue_valid = '0; set_src(2, 1, 3'd4); #1;
    checks++; if (b.stall !== 1'b0) begin errors++; $display("FAIL way_alu_young_stall: got %b expected 0", b.stall); end
    checks++; if (sel_of(2) !== 3'd2) begin errors++; $display("FAIL way_alu_young_sel: got %0d expected 2", sel_of(2)); end
    do_reset();
    b.advance = 1; set_way(0, 1, 1, 0, 3'd4); set_way(1, 1, 1, 1, 3'd4); cycle();
    b.advance = 0; b.issue_valid = '0; set_src(2, 1, 3'd4); #1;
    checks++; if (b.stall !== 1'b1) begin errors++; $display("FAIL way_load_young_stall: got %b expected 1", b.stall); end
  endtask

  task automatic test_used_and_wb();
    do_reset();
    b.advance = 1; set_way(0, 1, 1, 1, 3'd1); set_way(1, 1, 0, 0, 3'd7); cycle();
    b.advance = 0; b.issue_valid = '0;
    set_src(1, 0, 3'd1); set_src(2, 1, 3'd7); #1;
    checks++; if (sel_of(1) !== 3'd0) begin errors++; $display("FAIL unused_sel: got %0d expected 0", sel_of(1)); end
    checks++; if (sel_of(2) !== 3'd0) begin errors++; $display("FAIL nowb_sel: got %0d expected 0", sel_of(2)); end
    checks++; if (b.stall !== 1'b0) begin errors++; $display("FAIL unused_stall: got %b expected 0", b.stall); end
    set_src(1, 1, 3'd1); #1;
    checks++; if (b.stall !== 1'b1) begin errors++; $display("FAIL used_stall: got %b expected 1", b.stall); end
  endtask

  task automatic test_flush();
    do_reset();
    b.advance = 1; set_way(0, 1, 1, 0, 3'd4); cycle();
    set_way(0, 1, 1, 0, 3'd1); cycle();
    b.advance = 0; b.flush = 1; b.issue_valid = '0; cycle();
    b.flush = 0; set_src(0, 1, 3'd1); set_src(2, 1, 3'd4); #1;
    checks++; if (sel_of(0) !== 3'd0) begin errors++; $display("FAIL flush_hold_s0: got %0d expected 0", sel_of(0)); end
    checks++; if (sel_of(2) !== 3'd3) begin errors++; $display("FAIL flush_hold_s1: got %0d expected 3", sel_of(2)); end
    do_reset();
    b.advance = 1; set_way(0, 1, 1, 1, 3'd5); cycle();
    set_way(0, 1, 1, 0, 3'd6); set_src(0, 1, 3'd5); b.flush = 1; #1;
    checks++; if (b.stall !== 1'b1) begin errors++; $display("FAIL flush_pre_stall: got %b expected 1", b.stall); end
    cycle();
    b.flush = 0; b.issue_valid = '0; set_src(1, 1, 3'd6); #1;
    checks++; if (b.stall_cnt !== 16'd1) begin errors++; $display("FAIL flush_stall_cnt: got %0d expected 1", b.stall_cnt); end
    checks++; if (sel_of(1) !== 3'd0) begin errors++; $display("FAIL flush_adv_s0: got %0d expected 0", sel_of(1)); end
    checks++; if (sel_of(0) !== 3'd3) begin errors++; $display("FAIL flush_adv_s1: got %0d expected 3", sel_of(0)); end
  endtask

  task automatic test_saturation();
    int guard;
    rs = 1;
    bs.advance = 0; bs.flush = 0; bs.issue_valid = '0; bs.issue_wb = '0; bs.issue_load = '0;
    bs.issue_dest = '0; bs.src_addr = '0; bs.src_used = '0;
    cycle();
    rs = 0;
    // Self-dependent load group: stalls every other cycle and forwards every cycle.
    bs.advance = 1; bs.issue_valid = 2'b01; bs.issue_wb = 2'b01; bs.issue_load = 2'b01;
    bs.issue_dest = 6'd5; bs.src_used = 4'b0001; bs.src_addr = 12'd5;
    for (int i = 0; i < 2*(64+5); i++) cycle();
    checks++; if (bs.stall_cnt !== 6'h3F) begin errors++; $display("FAIL sat_stall_cnt: got %h expected 3f", bs.stall_cnt); end
    checks++; if (bs.fwd_cnt !== 6'h3F) begin errors++; $display("FAIL sat_fwd_cnt: got %h expected 3f", bs.fwd_cnt); end
    guard = 0;
    while (bs.stall !== 1'b1 && guard < 4) begin cycle(); guard++; end
    checks++; if (bs.stall !== 1'b1) begin errors++; $display("FAIL sat_stall_seen: got %b expected 1", bs.stall); end
    #2 rs = 1; #1;
    checks++; if (bs.stall !== 1'b0) begin errors++; $display("FAIL async_rst_stall: got %b expected 0", bs.stall); end
    checks++; if (bs.stall_cnt !== 6'd0) begin errors++; $display("FAIL async_rst_cnt: got %0d expected 0", bs.stall_cnt); end
    checks++; if (bs.fwd_sel !== 12'd0) begin errors++; $display("FAIL async_rst_sel: got %h expected 0", bs.fwd_sel); end
    cycle();
    rs = 0; #1;
    checks++; if (bs.fwd_sel[2:0] !== 3'd0) begin errors++; $display("FAIL post_rst_sel: got %0d expected 0", bs.fwd_sel[2:0]); end
  endtask

  initial begin
    rs = 1;
    test_reset();
    test_way_priority();
    test_load_use();
    test_age_override();
    test_used_and_wb();
    test_flush();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
